sync_fifo_prog: RTL and testbench



---
 rtl/sync_fifo_prog.sv | 100 ++++++++++
 tb/tb_sync_fifo_prog.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, synchronous flush and sticky
// overflow/underflow flags. Define FIFO_FWFT_EN for first-word-fall-through
// reads; otherwise rdata is registered with one cycle of latency.
module sync_fifo_prog #(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned ASIZE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  input  logic             rinc,
  input  logic             clr,
  input  logic [ASIZE:0]   afull_thr,
  input  logic [ASIZE:0]   aempty_thr,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty,
  output logic             walmost_full,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] FULL_CNT = (ASIZE+1)'(DEPTH);

  logic [DSIZE-1:0] mem [DEPTH];
  logic [ASIZE:0]   wptr, rptr;
  logic [ASIZE:0]   wptr_nxt, rptr_nxt, count_nxt;
  logic             re_c, we_c;

  // Accept/reject decisions and next pointer/occupancy values
  always_comb begin
    re_c      = rinc & ~rempty;
    we_c      = winc & (~wfull | re_c);
    wptr_nxt  = wptr + (ASIZE+1)'(we_c);
    rptr_nxt  = rptr + (ASIZE+1)'(re_c);
    count_nxt = wptr_nxt - rptr_nxt;
  end

  // Pointers, occupancy, registered status and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      rempty    <= 1'b1;
      wfull     <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      rempty    <= 1'b1;
      wfull     <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wptr      <= wptr_nxt;
      rptr      <= rptr_nxt;
      count     <= count_nxt;
      rempty    <= (count_nxt == '0);
      wfull     <= (count_nxt == FULL_CNT);
      overflow  <= overflow | (winc & ~we_c);
      underflow <= underflow | (rinc & ~re_c);
    end
  end

  // Storage array; a flush suppresses the write but leaves contents intact
  always_ff @(posedge clk) begin
    if (we_c && !clr) begin
      mem[wptr[ASIZE-1:0]] <= wdata;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is presented directly from the array
  assign rdata = mem[rptr[ASIZE-1:0]];
`else
  // Registered read port; same-slot write in the same cycle returns old data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (clr) begin
      rdata <= '0;
    end else if (re_c) begin
      rdata <= mem[rptr[ASIZE-1:0]];
    end
  end
`endif

  // Threshold flags follow the count register and thresholds immediately
  assign walmost_full  = (count >= afull_thr);
  assign ralmost_empty = (count <= aempty_thr);

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Testbench for sync_fifo_prog (DSIZE=8, ASIZE=4): directed scenarios plus
// random traffic, checked against a queue-based reference model.
module tb_sync_fifo_prog;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] wdata;
  logic       winc, rinc, clr;
  logic [4:0] afull_thr, aempty_thr;
  logic [7:0] rdata;
  logic       wfull, rempty, walmost_full, ralmost_empty, overflow, underflow;
  logic [4:0] count;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [7:0] q[$];
  bit         m_ovf, m_udf;
  logic [7:0] m_rd;

  sync_fifo_prog #(.DSIZE(8), .ASIZE(4)) dut (
    .clk(clk), .rst_n(rst_n), .wdata(wdata), .winc(winc), .rinc(rinc),
    .clr(clr), .afull_thr(afull_thr), .aempty_thr(aempty_thr),
    .rdata(rdata), .wfull(wfull), .rempty(rempty),
    .walmost_full(walmost_full), .ralmost_empty(ralmost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 0;
    m_udf = 0;
    m_rd  = 8'h00;
  endtask

  task automatic compare_all();
    int n;
    n = q.size();
    check("count", int'(count), n);
    check("rempty", int'(rempty), int'(n == 0));
    check("wfull", int'(wfull), int'(n == DEPTH));
    check("walmost_full", int'(walmost_full), int'(n >= int'(afull_thr)));
    check("ralmost_empty", int'(ralmost_empty), int'(n <= int'(aempty_thr)));
    check("overflow", int'(overflow), int'(m_ovf));
    check("underflow", int'(underflow), int'(m_udf));
`ifdef FIFO_FWFT_EN
    if (n > 0) check("rdata", int'(rdata), int'(q[0]));
`else
    check("rdata", int'(rdata), int'(m_rd));
`endif
  endtask

  // One clock cycle: drive, advance model at the edge, check just after it
  task automatic step(input bit w, input logic [7:0] d, input bit r, input bit c);
    bit was_full, re, we;
    winc  = w;
    wdata = d;
    rinc  = r;
    clr   = c;
    @(posedge clk);
    if (c) begin
      model_reset();
    end else begin
      was_full = (q.size() == DEPTH);
      re = r && (q.size() != 0);
      we = w && (!was_full || re);
      if (re) m_rd = q.pop_front();
      if (we) q.push_back(d);
      if (r && !re) m_udf = 1;
      if (w && !we) m_ovf = 1;
    end
    #1;
    compare_all();
  endtask

  task automatic fill_to_seven_with_overflow();
    for (int i = 0; i < DEPTH; i++) step(1, 8'($urandom), 0, 0);
    step(1, 8'hEE, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 8'h00, 1, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    winc = 0; rinc = 0; clr = 0; wdata = '0;
    afull_thr = 5'd0;
    aempty_thr = 5'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;
    afull_thr = 5'd16;
    #1;
    compare_all();

    // fill 0x01..0x10, then overflow attempt
    for (int i = 1; i <= DEPTH; i++) step(1, 8'(i), 0, 0);
    step(1, 8'hAA, 0, 0);
    // drain all plus one extra read
    for (int i = 0; i < DEPTH; i++) step(0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 1);

    // full with simultaneous read and write
    for (int i = 1; i <= DEPTH; i++) step(1, 8'(i), 0, 0);
    step(1, 8'h55, 1, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 1);

    // empty with simultaneous read and write
    step(1, 8'h3C, 1, 0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 1);

    // thresholds
    afull_thr  = 5'd12;
    aempty_thr = 5'd3;
    #1;
    compare_all();
    for (int i = 0; i < 12; i++) step(1, 8'($urandom), 0, 0);
    for (int i = 0; i < 9; i++) step(0, 8'h00, 1, 0);
    afull_thr  = 5'd20;
    aempty_thr = 5'd31;
    #1;
    compare_all();
    step(0, 8'h00, 0, 1);

    // pointer wrap with 10-word bursts
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 10; i++) step(1, 8'($urandom), 0, 0);
      for (int i = 0; i < 10; i++) step(0, 8'h00, 1, 0);
    end

    // flush with 7 words stored and overflow set; concurrent write ignored
    fill_to_seven_with_overflow();
    step(1, 8'h77, 0, 1);

    // asynchronous reset mid-cycle
    fill_to_seven_with_overflow();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // random traffic with varying bias, thresholds and rare flushes
    for (int seg = 0; seg < 15; seg++) begin
      int wp, rp;
      wp = $urandom_range(10, 90);
      rp = $urandom_range(10, 90);
      afull_thr  = 5'($urandom_range(0, 31));
      aempty_thr = 5'($urandom_range(0, 31));
      for (int i = 0; i < 200; i++) begin
        step($urandom_range(0, 99) < wp, 8'($urandom),
             $urandom_range(0, 99) < rp, $urandom_range(0, 199) == 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
